// File: rtl/xed_burst_collector_pkg.sv
// Shared constants for the XED burst collector: geometry, FSM encodings and
// the lane-to-chip byte mapping helper.
package xed_burst_collector_pkg;

    localparam int NUM_CHIPS  = 8;
    localparam int CHIP_BYTES = 16;
    localparam int CRC_BEAT   = 16;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_CRC     = 2'd2;

    // Lane c of a read-data beat carries the byte belonging to chip c
    function automatic logic [7:0] lane_byte(input logic [63:0] beat, input int c);
        return beat[8*c +: 8];
    endfunction

endpackage

// File: rtl/xed_lane_deser.sv
// One chip lane: collects CHIP_BYTES bytes MSB-first into a 128b word.
// The first shifted byte ends up in the top byte after a full burst.
module xed_lane_deser
    import xed_burst_collector_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic [7:0]   din,
    output logic [127:0] dout
);

    // Shift in one byte per accepted beat; clr restarts the word with din as byte 0
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (shift_en) begin
            if (clr) begin
                dout <= {{(8*CHIP_BYTES-8){1'b0}}, din};
            end else begin
                dout <= {dout[8*CHIP_BYTES-9:0], din};
            end
        end
    end

endmodule

// File: rtl/xed_burst_collector.sv
// Frames one XED read burst (16 data beats + 1 CRC beat) from the PHY read bus
// and presents the per-chip parallel view to the decoder, one data_valid pulse
// per complete burst. Outputs hold until the next commit.
//
// Handshake: input side is valid-only (a beat is accepted in every cycle that
// beat_valid is high, there is no ready); output side is a one-cycle data_valid
// strobe with no backpressure, data held stable between strobes.
module xed_burst_collector
    import xed_burst_collector_pkg::*;
#(
    parameter int DATA_BEATS     = 16,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat_valid,
    input  logic             burst_start,
    input  logic [63:0]      beat_data,
    input  logic [7:0]       beat_par,
    output logic             data_valid,
    output logic [127:0]     chip0_data,
    output logic [127:0]     chip1_data,
    output logic [127:0]     chip2_data,
    output logic [127:0]     chip3_data,
    output logic [127:0]     chip4_data,
    output logic [127:0]     chip5_data,
    output logic [127:0]     chip6_data,
    output logic [127:0]     chip7_data,
    output logic [7:0]       chip0_crc,
    output logic [7:0]       chip1_crc,
    output logic [7:0]       chip2_crc,
    output logic [7:0]       chip3_crc,
    output logic [7:0]       chip4_crc,
    output logic [7:0]       chip5_crc,
    output logic [7:0]       chip6_crc,
    output logic [7:0]       chip7_crc,
    output logic [63:0]      xor_parity_group0,
    output logic [63:0]      xor_parity_group1,
    output logic [7:0]       xor_parity_crc,
    output logic             frame_error,
    output logic             busy,
    output logic [CNT_W-1:0] burst_count,
    output logic [1:0]       fsm_state
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    if (DATA_BEATS != 16) begin : g_bad_beats
        $error("xed_burst_collector: DATA_BEATS must be 16");
    end

    logic [1:0]        state;
    logic [3:0]        beat_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [127:0]      shadow_data [NUM_CHIPS];
    logic [127:0]      shadow_par;
    logic [127:0]      out_data    [NUM_CHIPS];
    logic [7:0]        out_crc     [NUM_CHIPS];
    logic              shift_en;
    logic              commit;

    // Data beats shift into the lanes on a burst start or while collecting
    assign shift_en = beat_valid && (burst_start || state == ST_COLLECT);
    // A CRC beat carrying burst_start is a restart, never a commit
    assign commit   = beat_valid && !burst_start && state == ST_CRC;

    for (genvar c = 0; c < NUM_CHIPS; c++) begin : g_chip
        xed_lane_deser u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (burst_start),
            .shift_en (shift_en),
            .din      (lane_byte(beat_data, c)),
            .dout     (shadow_data[c])
        );
    end

    xed_lane_deser u_par_lane (
        .clk      (clk),
        .rst      (rst),
        .clr      (burst_start),
        .shift_en (shift_en),
        .din      (beat_par),
        .dout     (shadow_par)
    );

    // Burst framing FSM with beat/idle counters and error strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            idle_cnt    <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                ST_COLLECT, ST_CRC: begin
                    if (beat_valid && burst_start) begin
                        frame_error <= 1'b1;
                        state       <= ST_COLLECT;
                        beat_cnt    <= 4'd1;
                        idle_cnt    <= '0;
                    end else if (beat_valid) begin
                        idle_cnt <= '0;
                        if (state == ST_CRC) begin
                            state <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                            if (beat_cnt == 4'(CRC_BEAT - 1)) begin
                                state <= ST_CRC;
                            end
                        end
                    end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                        frame_error <= 1'b1;
                        state       <= ST_IDLE;
                        idle_cnt    <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                default: begin
                    idle_cnt <= '0;
                    if (beat_valid && burst_start) begin
                        state    <= ST_COLLECT;
                        beat_cnt <= 4'd1;
                    end else if (beat_valid) begin
                        frame_error <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Output registers load only on commit so the decoder sees stable data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHIPS; c++) begin
                out_data[c] <= '0;
                out_crc[c]  <= '0;
            end
            xor_parity_group0 <= '0;
            xor_parity_group1 <= '0;
            xor_parity_crc    <= '0;
            burst_count       <= '0;
            data_valid        <= 1'b0;
        end else begin
            data_valid <= commit;
            if (commit) begin
                for (int c = 0; c < NUM_CHIPS; c++) begin
                    out_data[c] <= shadow_data[c];
                    out_crc[c]  <= lane_byte(beat_data, c);
                end
                xor_parity_group0 <= shadow_par[63:0];
                xor_parity_group1 <= shadow_par[127:64];
                xor_parity_crc    <= beat_par;
                burst_count       <= burst_count + CNT_W'(1);
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    assign chip0_data = out_data[0];
    assign chip1_data = out_data[1];
    assign chip2_data = out_data[2];
    assign chip3_data = out_data[3];
    assign chip4_data = out_data[4];
    assign chip5_data = out_data[5];
    assign chip6_data = out_data[6];
    assign chip7_data = out_data[7];
    assign chip0_crc  = out_crc[0];
    assign chip1_crc  = out_crc[1];
    assign chip2_crc  = out_crc[2];
    assign chip3_crc  = out_crc[3];
    assign chip4_crc  = out_crc[4];
    assign chip5_crc  = out_crc[5];
    assign chip6_crc  = out_crc[6];
    assign chip7_crc  = out_crc[7];

endmodule
